rpc2_ctrl_reg_arbiter: RTL and testbench

- Arbitrates the AXI read-address (AR) and write-address (AW) channels of the register slave port into the single command interface (axi2ip_valid/axi2ip_rw_n) of the register-access logic.
- Captures the winning command and presents it downstream.
- Holds ownership until that transaction completes (read last-beat handshake or write done), so read and write bursts never interleave.
- Round-robin fairness between AR and AW, plus a busy-watchdog status flag.

---
 rtl/rpc2_ctrl_reg_arbiter_if.sv | 52 +++++
 rtl/rpc2_ctrl_reg_arbiter.sv | 143 ++++++++++++++
 tb/tb_rpc2_ctrl_reg_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpc2_ctrl_reg_arbiter_if.sv
// Register-port command bus between the AXI AR/AW channels,
// the arbiter and the register-access logic.
interface rpc2_ctrl_reg_arbiter_if;
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [1:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        ar_ready;

    logic        aw_valid;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [1:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_ready;

    logic        axi2ip_valid;
    logic        axi2ip_rw_n;
    logic [31:0] axi2ip_address;
    logic [7:0]  axi2ip_len;
    logic [1:0]  axi2ip_size;
    logic [1:0]  axi2ip_burst;

    logic        ip_ready;
    logic        ip_data_valid;
    logic        ip_data_last;
    logic        axi2ip_data_ready;
    logic        ip_wr_done;

    modport slave (
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst,
        output ar_ready,
        input  aw_valid, aw_addr, aw_len, aw_size, aw_burst,
        output aw_ready,
        output axi2ip_valid, axi2ip_rw_n, axi2ip_address,
        output axi2ip_len, axi2ip_size, axi2ip_burst,
        input  ip_ready, ip_data_valid, ip_data_last,
        input  axi2ip_data_ready, ip_wr_done
    );

    modport master (
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst,
        input  ar_ready,
        output aw_valid, aw_addr, aw_len, aw_size, aw_burst,
        input  aw_ready,
        input  axi2ip_valid, axi2ip_rw_n, axi2ip_address,
        input  axi2ip_len, axi2ip_size, axi2ip_burst,
        output ip_ready, ip_data_valid, ip_data_last,
        output axi2ip_data_ready, ip_wr_done
    );
endinterface

// File: rtl/rpc2_ctrl_reg_arbiter.sv
// Round-robin AR/AW arbiter for the register slave port.
// Owns one transaction at a time and flags stuck transactions.
module rpc2_ctrl_reg_arbiter #(
    parameter logic        WR_FIRST   = 1'b0,
    parameter logic [15:0] WDOG_LIMIT = 16'd1024
) (
    input  logic clk,
    input  logic reset_n,
    rpc2_ctrl_reg_arbiter_if.slave bus,
    output logic arb_busy,
    output logic timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_BUSY = 2'd2,
        WR_BUSY = 2'd3
    } state_t;

    state_t      state;
    logic        last_wr;
    logic [15:0] wdog_cnt;
    logic        grant_rd;
    logic        grant_wr;
    logic        rd_last;

    assign rd_last = bus.ip_data_valid & bus.ip_data_last
                   & bus.axi2ip_data_ready;

    // Grant only while idle; a tie goes to the side not served last.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state == IDLE) begin
            unique case (1'b1)
                (bus.ar_valid && bus.aw_valid): begin
                    grant_rd = last_wr;
                    grant_wr = ~last_wr;
                end
                (bus.ar_valid && !bus.aw_valid): grant_rd = 1'b1;
                (!bus.ar_valid && bus.aw_valid): grant_wr = 1'b1;
                default: ;
            endcase
        end
    end

    // Readies are held low while reset is applied.
    assign bus.ar_ready = reset_n & grant_rd;
    assign bus.aw_ready = reset_n & grant_wr;
    assign arb_busy     = (state != IDLE);

    // Command capture and ownership state machine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            last_wr            <= ~WR_FIRST;
            bus.axi2ip_valid   <= 1'b0;
            bus.axi2ip_rw_n    <= 1'b0;
            bus.axi2ip_address <= 32'd0;
            bus.axi2ip_len     <= 8'd0;
            bus.axi2ip_size    <= 2'd0;
            bus.axi2ip_burst   <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.axi2ip_valid <= 1'b0;
                    if (grant_rd) begin
                        bus.axi2ip_address <= bus.ar_addr;
                        bus.axi2ip_len     <= bus.ar_len;
                        bus.axi2ip_size    <= bus.ar_size;
                        bus.axi2ip_burst   <= bus.ar_burst;
                    end else begin
                        bus.axi2ip_address <= bus.aw_addr;
                        bus.axi2ip_len     <= bus.aw_len;
                        bus.axi2ip_size    <= bus.aw_size;
                        bus.axi2ip_burst   <= bus.aw_burst;
                    end
                    if (grant_rd || grant_wr) begin
                        bus.axi2ip_valid <= 1'b1;
                        bus.axi2ip_rw_n  <= grant_rd;
                        last_wr          <= grant_wr;
                        state            <= CMD;
                    end else begin
                        bus.axi2ip_address <= bus.axi2ip_address;
                        bus.axi2ip_len     <= bus.axi2ip_len;
                        bus.axi2ip_size    <= bus.axi2ip_size;
                        bus.axi2ip_burst   <= bus.axi2ip_burst;
                    end
                end
                CMD: begin
                    if (bus.ip_ready) begin
                        bus.axi2ip_valid <= 1'b0;
                        state <= bus.axi2ip_rw_n ? RD_BUSY : WR_BUSY;
                    end
                end
                RD_BUSY: begin
                    if (rd_last) begin
                        state <= IDLE;
                    end
                end
                WR_BUSY: begin
                    if (bus.ip_wr_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.axi2ip_valid <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

    // Busy-time counter with a sticky timeout flag; never touches the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt    <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wdog_cnt <= 16'd0;
            end else if (wdog_cnt != 16'hFFFF) begin
                wdog_cnt <= wdog_cnt + 16'd1;
            end
            if (WDOG_LIMIT != 16'd0 && wdog_cnt == WDOG_LIMIT) begin
                timeout_err <= 1'b1;
            end
        end
    end

    a_ready_excl: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(bus.ar_ready && bus.aw_ready)
    );

    a_cmd_hold: assert property (
        @(posedge clk) disable iff (!reset_n)
        (bus.axi2ip_valid && !bus.ip_ready) |=>
        (bus.axi2ip_valid && $stable(bus.axi2ip_address))
    );

endmodule

// File: tb/tb_rpc2_ctrl_reg_arbiter.sv
// Scoreboard bench for rpc2_ctrl_reg_arbiter: expected commands are
// queued when stimulus is driven and retired at the downstream handshake.
module tb_rpc2_ctrl_reg_arbiter;

    localparam logic WR_FIRST = 1'b0;

    typedef struct packed {
        logic        rw_n;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  size;
        logic [1:0]  burst;
    } cmd_t;

    logic clk = 1'b0;
    logic reset_n;
    logic arb_busy;
    logic timeout_err;

    int   n_chk  = 0;
    int   n_fail = 0;
    cmd_t sb[$];
    cmd_t exp_c;
    cmd_t act_c;

    rpc2_ctrl_reg_arbiter_if bus ();

    rpc2_ctrl_reg_arbiter #(
        .WR_FIRST   (WR_FIRST),
        .WDOG_LIMIT (16'd16)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic rw, input logic [31:0] a,
                                input logic [7:0] l, input logic [1:0] s,
                                input logic [1:0] b);
        cmd_t c;
        c.rw_n  = rw;
        c.addr  = a;
        c.len   = l;
        c.size  = s;
        c.burst = b;
        return c;
    endfunction

    // Retire one expected command per downstream handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.ar_ready || bus.aw_ready)
                check("ready_excl", 64'(bus.ar_ready & bus.aw_ready), 64'd0);
            if (bus.axi2ip_valid && bus.ip_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_c = sb.pop_front();
                    act_c = mk(bus.axi2ip_rw_n, bus.axi2ip_address,
                               bus.axi2ip_len, bus.axi2ip_size,
                               bus.axi2ip_burst);
                    check("cmd", 64'(act_c), 64'(exp_c));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.ar_valid = 0; bus.ar_addr = 0; bus.ar_len = 0;
        bus.ar_size = 0;  bus.ar_burst = 0;
        bus.aw_valid = 0; bus.aw_addr = 0; bus.aw_len = 0;
        bus.aw_size = 0;  bus.aw_burst = 0;
        bus.ip_ready = 0; bus.ip_data_valid = 0; bus.ip_data_last = 0;
        bus.axi2ip_data_ready = 0; bus.ip_wr_done = 0;
    endtask

    task automatic set_ar(input logic v, input logic [31:0] a,
                          input logic [7:0] l);
        bus.ar_valid = v; bus.ar_addr = a; bus.ar_len = l;
        bus.ar_size = 2'd2; bus.ar_burst = 2'd1;
    endtask

    task automatic set_aw(input logic v, input logic [31:0] a,
                          input logic [7:0] l);
        bus.aw_valid = v; bus.aw_addr = a; bus.aw_len = l;
        bus.aw_size = 2'd2; bus.aw_burst = 2'd1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    // Wait (bounded) for a grant; n = idle negedges before it appeared.
    task automatic wait_grant(output logic rd, output int n);
        n = 0;
        @(negedge clk);
        while (!(bus.ar_ready || bus.aw_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.ar_ready || bus.aw_ready))
            check("grant_timeout", 64'd0, 64'd1);
        rd = bus.ar_ready;
    endtask

    task automatic complete(input logic rd);
        if (rd) begin
            bus.ip_data_valid = 1;
            bus.ip_data_last = 1;
            bus.axi2ip_data_ready = 1;
        end else begin
            bus.ip_wr_done = 1;
        end
        tick();
        bus.ip_data_valid = 0;
        bus.ip_data_last = 0;
        bus.axi2ip_data_ready = 0;
        bus.ip_wr_done = 0;
    endtask

    initial begin
        logic rd;
        logic exp_rd;
        logic last_wr_m;
        int   n;

        // Reset with both requests pending: nothing may be granted.
        reset_n = 0;
        clr_inputs();
        set_ar(1, 32'h100, 8'd0);
        set_aw(1, 32'h200, 8'd0);
        bus.ip_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
        check("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
        check("rst_valid", 64'(bus.axi2ip_valid), 64'd0);
        check("rst_rw_n", 64'(bus.axi2ip_rw_n), 64'd0);
        check("rst_addr", 64'(bus.axi2ip_address), 64'd0);
        check("rst_busy", 64'(arb_busy), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        @(posedge clk);
        #1 reset_n = 1;

        // Both held: round robin starting from ~WR_FIRST history.
        last_wr_m = ~WR_FIRST;
        for (int i = 0; i < 4; i++) begin
            exp_rd = last_wr_m;
            last_wr_m = ~exp_rd;
            sb.push_back(mk(exp_rd, exp_rd ? 32'h100 : 32'h200,
                            8'd0, 2'd2, 2'd1));
            wait_grant(rd, n);
            check("rr_grant_rd", 64'(rd), 64'(exp_rd));
            tick();
            tick();
            check("rr_busy", 64'(arb_busy), 64'd1);
            check("rr_no_ready", 64'(bus.ar_ready | bus.aw_ready), 64'd0);
            complete(rd);
        end
        bus.ar_valid = 0;
        bus.aw_valid = 0;
        check("rr_sb_empty", 64'(sb.size()), 64'd0);

        // Single read.
        do_reset();
        bus.ip_ready = 1;
        set_ar(1, 32'h8, 8'd0);
        sb.push_back(mk(1'b1, 32'h8, 8'd0, 2'd2, 2'd1));
        wait_grant(rd, n);
        check("rd_grant", 64'(rd), 64'd1);
        check("rd_grant_lat", 64'(n), 64'd0);
        tick();
        bus.ar_valid = 0;
        @(negedge clk);
        check("rd_valid", 64'(bus.axi2ip_valid), 64'd1);
        check("rd_rw_n", 64'(bus.axi2ip_rw_n), 64'd1);
        check("rd_addr", 64'(bus.axi2ip_address), 64'h8);
        tick();
        check("rd_valid_drop", 64'(bus.axi2ip_valid), 64'd0);
        check("rd_busy", 64'(arb_busy), 64'd1);
        complete(1'b1);
        check("rd_busy_fall", 64'(arb_busy), 64'd0);

        // Backpressure in CMD while input addresses wander.
        do_reset();
        set_aw(1, 32'h40, 8'd1);
        sb.push_back(mk(1'b0, 32'h40, 8'd1, 2'd2, 2'd1));
        wait_grant(rd, n);
        check("bp_grant_rd", 64'(rd), 64'd0);
        tick();
        bus.aw_valid = 0;
        for (int i = 0; i < 5; i++) begin
            bus.ar_addr = $urandom;
            bus.aw_addr = $urandom;
            @(negedge clk);
            check("bp_valid", 64'(bus.axi2ip_valid), 64'd1);
            check("bp_addr", 64'(bus.axi2ip_address), 64'h40);
            tick();
        end
        bus.ip_ready = 1;
        tick();
        check("bp_valid_drop", 64'(bus.axi2ip_valid), 64'd0);
        check("bp_busy", 64'(arb_busy), 64'd1);
        complete(1'b1);
        check("bp_stray_rd_last", 64'(arb_busy), 64'd1);
        complete(1'b0);
        check("bp_done", 64'(arb_busy), 64'd0);
        check("bp_timeout", 64'(timeout_err), 64'd0);

        // Write burst, len=3, stray read-last mid-burst.
        set_aw(1, 32'h80, 8'd3);
        sb.push_back(mk(1'b0, 32'h80, 8'd3, 2'd2, 2'd1));
        wait_grant(rd, n);
        check("wb_grant_rd", 64'(rd), 64'd0);
        tick();
        bus.aw_valid = 0;
        tick();
        for (int b = 0; b < 4; b++) begin
            bus.ip_wr_done = (b == 3);
            bus.ip_data_last = (b == 1);
            bus.ip_data_valid = (b == 1);
            bus.axi2ip_data_ready = (b == 1);
            tick();
            check("wb_busy", 64'(arb_busy), 64'(b < 3));
        end
        bus.ip_wr_done = 0;
        bus.ip_data_last = 0;
        bus.ip_data_valid = 0;
        bus.axi2ip_data_ready = 0;

        // Watchdog: counter hits 16 after 16 busy edges,
        // flag is registered so it shows from edge 17 on.
        do_reset();
        bus.ip_ready = 1;
        set_aw(1, 32'hC0, 8'd0);
        sb.push_back(mk(1'b0, 32'hC0, 8'd0, 2'd2, 2'd1));
        wait_grant(rd, n);
        tick();
        bus.aw_valid = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("wdog_flag", 64'(timeout_err), 64'(k >= 17));
        end
        complete(1'b0);
        check("wdog_idle", 64'(arb_busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            check("wdog_sticky", 64'(timeout_err), 64'd1);
            tick();
        end

        // Reset while in RD_BUSY with a write pending.
        do_reset();
        bus.ip_ready = 1;
        set_ar(1, 32'h300, 8'd0);
        sb.push_back(mk(1'b1, 32'h300, 8'd0, 2'd2, 2'd1));
        wait_grant(rd, n);
        tick();
        bus.ar_valid = 0;
        tick();
        set_aw(1, 32'h400, 8'd0);
        tick();
        check("mr_busy", 64'(arb_busy), 64'd1);
        check("mr_aw_blocked", 64'(bus.aw_ready), 64'd0);
        #2 reset_n = 0;
        #1;
        check("mr_valid", 64'(bus.axi2ip_valid), 64'd0);
        check("mr_rw_n", 64'(bus.axi2ip_rw_n), 64'd0);
        check("mr_addr", 64'(bus.axi2ip_address), 64'd0);
        check("mr_busy_rst", 64'(arb_busy), 64'd0);
        check("mr_aw_ready", 64'(bus.aw_ready), 64'd0);
        sb.push_back(mk(1'b0, 32'h400, 8'd0, 2'd2, 2'd1));
        @(posedge clk);
        #1 reset_n = 1;
        wait_grant(rd, n);
        check("mr_regrant_wr", 64'(rd), 64'd0);
        check("mr_regrant_lat", 64'(n), 64'd0);
        tick();
        bus.aw_valid = 0;
        tick();
        complete(1'b0);
        check("mr_done", 64'(arb_busy), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
